// File: rtl/ifetch_buffer.sv
// Fetch PC generator and instruction FIFO feeding decode, with redirect flush.
// Define IFETCH_BUFFER_BYPASS_EN to forward a fetch straight to decode when the buffer is empty.
module ifetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_EN,
    input  logic             i_FETCH_VALID,
    input  logic [31:0]      i_FETCH_INSTRUCTION,
    output logic             o_FETCH_NEXT,
    output logic [31:0]      o_FETCH_PC,
    input  logic             i_REDIRECT,
    input  logic [31:0]      i_REDIRECT_PC,
    input  logic             i_DECODE_READY,
    output logic             o_DECODE_VALID,
    output logic [31:0]      o_DECODE_INSTRUCTION,
    output logic [31:0]      o_DECODE_PC,
    output logic [PTR_W:0]   o_LEVEL
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [31:0]    NOP      = 32'h0000_0013;

    logic [31:0]      instr_mem_q [DEPTH];
    logic [31:0]      pc_mem_q    [DEPTH];
    logic [31:0]      pc_q,  pc_d;
    logic [PTR_W-1:0] rd_q,  rd_d;
    logic [PTR_W-1:0] wr_q,  wr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    logic empty, full, fetch_next, fetch_take, push, pop, buf_valid, bypass;

    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == FULL_CNT);
    assign fetch_next = i_EN & ~i_RST & ~i_REDIRECT & ~full;
    assign fetch_take = fetch_next & i_FETCH_VALID;
    assign buf_valid  = i_EN & ~i_REDIRECT & ~empty;

`ifdef IFETCH_BUFFER_BYPASS_EN
    assign bypass = fetch_take & empty & i_DECODE_READY;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed fetch consumes the request but is never written into the FIFO.
    assign push = fetch_take & ~bypass;
    assign pop  = buf_valid & i_DECODE_READY;

    always_comb begin
        pc_d  = pc_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (i_REDIRECT) begin
            pc_d  = {i_REDIRECT_PC[31:2], 2'b00};
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (fetch_take) pc_d = pc_q + 32'd4;
            if (push)       wr_d = wr_q + PTR_W'(1);
            if (pop)        rd_d = rd_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            pc_q  <= RESET_PC;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push) begin
            instr_mem_q[wr_q] <= i_FETCH_INSTRUCTION;
            pc_mem_q[wr_q]    <= pc_q;
        end
    end

    always_comb begin
        o_DECODE_VALID       = buf_valid | bypass;
        o_DECODE_INSTRUCTION = NOP;
        o_DECODE_PC          = pc_q;
        if (!empty) begin
            o_DECODE_INSTRUCTION = instr_mem_q[rd_q];
            o_DECODE_PC          = pc_mem_q[rd_q];
        end else if (bypass) begin
            o_DECODE_INSTRUCTION = i_FETCH_INSTRUCTION;
            o_DECODE_PC          = pc_q;
        end
    end

    assign o_FETCH_NEXT = fetch_next;
    assign o_FETCH_PC   = pc_q;
    assign o_LEVEL      = cnt_q;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed self-checking bench for ifetch_buffer: default instance plus one with a
// near-wrap RESET_PC; bypass expectations follow IFETCH_BUFFER_BYPASS_EN.
module tb_ifetch_buffer;

    logic        clk = 1'b0;
    logic        rst, en, fv, redir, rdy;
    logic [31:0] finst, rpc;
    logic        fn, dv;
    logic [31:0] fpc, dinst, dpc;
    logic [2:0]  lvl;

    logic        en2, fv2, rdy2;
    logic [31:0] finst2;
    logic        fn2, dv2;
    logic [31:0] fpc2, dinst2, dpc2;
    logic [2:0]  lvl2;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [31:0] pcm;
    logic [31:0] wrap_pc [3];

    always #5 clk = ~clk;

    ifetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
        .i_CLK(clk), .i_RST(rst), .i_EN(en),
        .i_FETCH_VALID(fv), .i_FETCH_INSTRUCTION(finst),
        .o_FETCH_NEXT(fn), .o_FETCH_PC(fpc),
        .i_REDIRECT(redir), .i_REDIRECT_PC(rpc),
        .i_DECODE_READY(rdy), .o_DECODE_VALID(dv),
        .o_DECODE_INSTRUCTION(dinst), .o_DECODE_PC(dpc), .o_LEVEL(lvl)
    );

    ifetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .i_CLK(clk), .i_RST(rst), .i_EN(en2),
        .i_FETCH_VALID(fv2), .i_FETCH_INSTRUCTION(finst2),
        .o_FETCH_NEXT(fn2), .o_FETCH_PC(fpc2),
        .i_REDIRECT(1'b0), .i_REDIRECT_PC(32'h0),
        .i_DECODE_READY(rdy2), .o_DECODE_VALID(dv2),
        .o_DECODE_INSTRUCTION(dinst2), .o_DECODE_PC(dpc2), .o_LEVEL(lvl2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        wrap_pc[0] = 32'hFFFF_FFFC;
        wrap_pc[1] = 32'h0000_0000;
        wrap_pc[2] = 32'h0000_0004;

        // reset beats a simultaneous redirect and blocks the fetch request
        rst = 1; en = 1; fv = 0; finst = 0; redir = 1; rpc = 32'h500; rdy = 0;
        en2 = 0; fv2 = 0; finst2 = 0; rdy2 = 0;
        #1;
        chk("rst_fetch_next", fn, 0);
        tick(); tick();
        rst = 0; redir = 0; en = 0;
        #1;
        chk("rst_level", lvl, 0);
        chk("rst_dvalid", dv, 0);
        chk("rst_fpc", fpc, 32'h0);
        chk("rst_nop", dinst, 32'h13);
        chk("en0_fetch_next", fn, 0);
        chk("rst_fpc_wrap", fpc2, 32'hFFFF_FFF8);

        // PC wrap through 2^32
        en2 = 1; fv2 = 1;
        for (int i = 0; i < 3; i++) begin
            finst2 = 32'hB000_0000 + i;
            tick();
            chk("wrap_fpc", fpc2, wrap_pc[i]);
        end
        chk("wrap_level", lvl2, 3);
        fv2 = 0; rdy2 = 1;
        #1;
        chk("wrap_dv", dv2, 1);
        chk("wrap_dpc0", dpc2, 32'hFFFF_FFF8);
        tick();
        chk("wrap_dpc1", dpc2, 32'hFFFF_FFFC);
        tick();
        chk("wrap_dpc2", dpc2, 32'h0);
        chk("wrap_dinst2", dinst2, 32'hB000_0002);
        tick();
        chk("wrap_empty", dv2, 0);
        en2 = 0;

        // streaming: one push, then push+pop every cycle with decode trailing by one
        en = 1; fv = 1; rdy = 0; pcm = 0; finst = 32'hA000_0000 + pcm;
        #1;
        chk("s_fn", fn, 1);
        chk("s_fpc0", fpc, 0);
        chk("s_dv0", dv, 0);
        tick(); pcm += 4;
        chk("s_lvl1", lvl, 1);
        chk("s_dpc0", dpc, 0);
        rdy = 1;
        for (int k = 1; k <= 4; k++) begin
            finst = 32'hA000_0000 + pcm;
            tick(); pcm += 4;
            chk("s_fpc", fpc, pcm);
            chk("s_dpc", dpc, pcm - 4);
            chk("s_dinst", dinst, 32'hA000_0000 + pcm - 4);
            chk("s_lvl", lvl, 1);
        end
        redir = 1; rpc = 32'h0;
        #1;
        chk("clr_dv", dv, 0);
        chk("clr_fn", fn, 0);
        tick();
        redir = 0; fv = 0; pcm = 0;
        #1;
        chk("clr_lvl", lvl, 0);
        chk("clr_fpc", fpc, 0);

        // fill to full, extra fetch ignored, then drain in order
        rdy = 0; fv = 1;
        for (int k = 1; k <= 4; k++) begin
            finst = 32'hA000_0000 + pcm;
            tick(); pcm += 4;
            chk("fill_lvl", lvl, k);
        end
        chk("full_fn", fn, 0);
        chk("full_fpc", fpc, 16);
        finst = 32'hEEEE_EEEE;
        tick();
        chk("full_lvl_hold", lvl, 4);
        chk("full_fpc_hold", fpc, 16);
        chk("full_head_inst", dinst, 32'hA000_0000);
        rdy = 1;
        #1;
        chk("full_pop_dv", dv, 1);
        chk("full_no_pass", fn, 0);
        tick();
        chk("drain_lvl3", lvl, 3);
        chk("drain_dpc4", dpc, 4);
        chk("drain_fn", fn, 1);
        chk("drain_fpc", fpc, 16);
        fv = 0;
        tick();
        chk("drain_dpc8", dpc, 8);
        tick();
        chk("drain_dpc12", dpc, 12);
        chk("drain_dinst12", dinst, 32'hA000_000C);
        tick();
        chk("drain_lvl0", lvl, 0);
        chk("drain_dv0", dv, 0);
        chk("drain_nop", dinst, 32'h13);

        // redirect with 3 entries buffered, misaligned target
        rdy = 0; fv = 1;
        for (int k = 0; k < 3; k++) begin
            finst = 32'hA000_0000 + pcm;
            tick(); pcm += 4;
        end
        chk("rd_lvl3", lvl, 3);
        chk("rd_fpc28", fpc, 28);
        redir = 1; rpc = 32'h103; rdy = 1;
        #1;
        chk("rd_same_dv", dv, 0);
        chk("rd_same_fn", fn, 0);
        tick();
        redir = 0; fv = 0;
        #1;
        chk("rd_lvl0", lvl, 0);
        chk("rd_fpc", fpc, 32'h100);
        chk("rd_dv0", dv, 0);
        pcm = 32'h100; fv = 1; rdy = 0; finst = 32'hA000_0000 + pcm;
        tick(); pcm += 4;
        chk("rd_issue_dv", dv, 1);
        chk("rd_issue_dpc", dpc, 32'h100);
        chk("rd_issue_dinst", dinst, 32'hA000_0100);
        chk("rd_issue_fpc", fpc, 32'h104);
        fv = 0; redir = 1; rpc = 32'h200;
        tick();
        rpc = 32'h302;
        tick();
        redir = 0;
        #1;
        chk("b2b_fpc", fpc, 32'h300);
        chk("b2b_lvl", lvl, 0);
        pcm = 32'h300;

        // steady push+pop at level 2 across pointer wrap, with an enable freeze
        rdy = 0; fv = 1;
        for (int k = 0; k < 2; k++) begin
            finst = 32'hA000_0000 + pcm;
            tick(); pcm += 4;
        end
        chk("pp_lvl2", lvl, 2);
        rdy = 1;
        for (int j = 1; j <= 5; j++) begin
            if (j == 4) begin
                en = 0;
                #1;
                chk("frz_dv", dv, 0);
                chk("frz_fn", fn, 0);
                tick(); tick();
                chk("frz_lvl", lvl, 2);
                chk("frz_fpc", fpc, pcm);
                chk("frz_head", dpc, 32'h30C);
                en = 1;
            end
            finst = 32'hA000_0000 + pcm;
            tick(); pcm += 4;
            chk("pp_lvl", lvl, 2);
            chk("pp_dpc", dpc, 32'h300 + 4 * j);
            chk("pp_dinst", dinst, 32'hA000_0300 + 4 * j);
        end
        fv = 0;
        tick(); tick();
        chk("pp_drain", lvl, 0);

        // empty buffer, fetch and decode ready together
        fv = 1; rdy = 1; finst = 32'hDEAD_BEEF;
`ifdef IFETCH_BUFFER_BYPASS_EN
        #1;
        chk("byp_dv", dv, 1);
        chk("byp_dinst", dinst, 32'hDEAD_BEEF);
        chk("byp_dpc", dpc, pcm);
        tick(); pcm += 4;
        fv = 0;
        #1;
        chk("byp_lvl", lvl, 0);
        chk("byp_fpc", fpc, pcm);
        chk("byp_dv_after", dv, 0);
`else
        #1;
        chk("nobyp_dv", dv, 0);
        chk("nobyp_nop", dinst, 32'h13);
        tick(); pcm += 4;
        fv = 0;
        #1;
        chk("nobyp_lvl1", lvl, 1);
        chk("nobyp_dv_late", dv, 1);
        chk("nobyp_dinst", dinst, 32'hDEAD_BEEF);
        chk("nobyp_dpc", dpc, pcm - 4);
        chk("nobyp_fpc", fpc, pcm);
        tick();
        chk("nobyp_lvl0", lvl, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
Instruction buffer and PC generator between the fetch stage and decode.
- Owns the fetch program counter and drives the fetch-next request.
- Queues each granted instruction with its PC in a small FIFO.
- Presents entries to decode with a valid/ready handshake.
- Flushes and re-targets on a redirect (branch, jump or trap) from execute.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
RESET_PC, 32'h00000000, fetch PC loaded at reset
PTR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
- i_CLK  in  1  clock; all state updates on the rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_EN  in  1  core enable; low freezes fetch and issue.
- i_FETCH_VALID  in  1  fetch stage has returned a granted instruction this cycle.
- i_FETCH_INSTRUCTION  in  32  instruction word from fetch.
- o_FETCH_NEXT  out  1  request the next instruction from fetch.
- o_FETCH_PC  out  32  address of the instruction currently requested.
- i_REDIRECT  in  1  flush and re-target request.
- i_REDIRECT_PC  in  32  new fetch target.
- i_DECODE_READY  in  1  decode accepts an entry this cycle.
- o_DECODE_VALID  out  1  head entry is valid.
- o_DECODE_INSTRUCTION  out  32  head instruction.
- o_DECODE_PC  out  32  PC of the head instruction.
- o_LEVEL  out  PTR_W+1  number of occupied entries.

Behaviour:
Reset:
- Takes effect on the clock edge while i_RST=1.
- Afterwards: pc_req=RESET_PC, rd_ptr=wr_ptr=0, count=0.
- Outputs after reset: o_DECODE_VALID=0, o_LEVEL=0, o_FETCH_PC=RESET_PC.
- o_DECODE_INSTRUCTION reads 32'h00000013 (NOP) whenever the buffer is empty.
- Reset overrides every other input, including i_REDIRECT.

Request and push:
- o_FETCH_NEXT = i_EN & ~i_RST & ~i_REDIRECT & (count != DEPTH). Combinational.
- o_FETCH_PC = pc_req.
- push = o_FETCH_NEXT & i_FETCH_VALID.
- On push: write {instruction, pc_req} at wr_ptr; wr_ptr+1 modulo DEPTH; pc_req+4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
- i_FETCH_VALID while o_FETCH_NEXT=0 is ignored and leaves no state change.

Pop and issue:
- o_DECODE_VALID = i_EN & ~i_REDIRECT & (count != 0).
- Head data is driven combinationally from rd_ptr.
- pop = o_DECODE_VALID & i_DECODE_READY. On pop, rd_ptr+1 modulo DEPTH.
- Push-to-issue latency is 1 cycle: an entry written at edge N is visible on o_DECODE_VALID after edge N.

Count:
- push only: +1. pop only: -1. Push and pop together: unchanged.
- When full, o_FETCH_NEXT stays low even if a pop occurs in the same cycle (no full-pass).
- Empty with a push: no pop that cycle, because the entry is not yet visible.

Redirect (highest priority after reset; honoured even when i_EN=0):
- Same cycle: o_FETCH_NEXT=0, o_DECODE_VALID=0, push and pop both suppressed.
- Next edge: rd_ptr=wr_ptr=0, count=0, pc_req = {i_REDIRECT_PC[31:2],2'b00}.
- Fetch resumes the following cycle at the new PC.
- Back-to-back redirects: the last one wins.

i_EN=0:
- No request, no issue, no state change except redirect.
- Buffered entries are retained.

o_LEVEL = count, registered.

Optional Feature:
IFETCH_BUFFER_BYPASS_EN
- Defined: when count==0, i_EN=1, no redirect, i_FETCH_VALID=1 and i_DECODE_READY=1:
  - the fetched instruction and pc_req go straight to decode in the same cycle;
  - o_DECODE_VALID=1; nothing is written; pc_req still advances by 4; count stays 0.
  - In this case o_DECODE_VALID depends combinationally on i_FETCH_VALID.
- Undefined: no bypass; minimum push-to-issue latency is 1 cycle, as above.

Test Plan:
1. Reset, then i_EN=1, fetch valid every cycle, decode ready=1 -> o_FETCH_PC steps 0,4,8,...; o_DECODE_PC trails by one cycle (bypass off); o_LEVEL holds at 1 after first push.
2. Decode ready=0, DEPTH=4, feed instructions A,B,C,D,E -> A–D stored; o_LEVEL=4; o_FETCH_NEXT=0; E not accepted; o_FETCH_PC=16. Raise ready -> A,B,C,D issue in order with PCs 0,4,8,12; fetch resumes at 16 after the first pop.
3. With 3 entries buffered, assert i_REDIRECT, i_REDIRECT_PC=32'h00000103 -> same cycle o_DECODE_VALID=0 and o_FETCH_NEXT=0; next cycle o_LEVEL=0, o_FETCH_PC=32'h00000100; the next issued entry has PC 32'h100.
4. RESET_PC=32'hFFFFFFF8, three pushes -> stored PCs FFFFFFF8, FFFFFFFC, 00000000; o_FETCH_PC=4.
5. Level 2, simultaneous push and pop for 5 cycles -> o_LEVEL stays 2; FIFO order preserved across pointer wrap. Drop i_EN mid-run -> contents and pointers frozen; resumes unchanged when i_EN returns.
6. Bypass on, empty buffer, fetch valid and ready in the same cycle -> o_DECODE_VALID=1 in that cycle with o_DECODE_INSTRUCTION = input word; o_LEVEL stays 0. Bypass off -> same stimulus gives valid one cycle later, with o_LEVEL=1 in between.
